gpi_cond: RTL and testbench



---
 rtl/gpi_cond.sv | 85 ++++++++
 tb/tb_gpi_cond.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gpi_cond.sv
// gpi_cond: input conditioner for eight active-low discrete pins.
// The pins are synchronised to wb_clk, each channel is debounced against a
// shared prescaled tick, and press/release strobes are raised in the same
// cycle as the debounced level changes.
module gpi_cond #(
  parameter int CLK_DIV = 50000,
  parameter int DB_CNT  = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic [7:0] pin_i,
  output logic [7:0] gpi,
  output logic [7:0] fall,
  output logic [7:0] rise,
  output logic       tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DB_CNT - 1);

  logic [7:0]    s1;
  logic [7:0]    s;
  logic [PW-1:0] pcnt;
  logic [CW-1:0] c [8];

  // Two-flop synchroniser; resets to the inactive (high) level.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      s1 <= 8'hFF;
      s  <= 8'hFF;
    end else begin
      s1 <= pin_i;
      s  <= s1;
    end
  end

  // Prescaler wrapping at CLK_DIV-1; tick is registered so the first one
  // appears CLK_DIV cycles after reset release.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (pcnt == P_LAST) begin
      pcnt <= '0;
      tick <= 1'b1;
    end else begin
      pcnt <= pcnt + PW'(1);
      tick <= 1'b0;
    end
  end

  // Per-channel debounce: any agreement clears progress, DB_CNT mismatching
  // ticks commit the new level together with its event strobe.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      gpi  <= 8'hFF;
      fall <= 8'h00;
      rise <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        c[i] <= '0;
      end
    end else begin
      fall <= 8'h00;
      rise <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (s[i] == gpi[i]) begin
          c[i] <= '0;
        end else if (tick && (c[i] == C_LAST)) begin
          gpi[i] <= s[i];
          c[i]   <= '0;
          if (s[i] == 1'b0) begin
            fall[i] <= 1'b1;
          end else begin
            rise[i] <= 1'b1;
          end
        end else if (tick) begin
          c[i] <= c[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gpi_cond.sv
// Directed testbench for gpi_cond with CLK_DIV=4, DB_CNT=3.
// Inputs change on the falling edge and outputs are sampled there too, so
// at the k-th falling edge after a reference point the bench sees the state
// left by the k-th rising edge.
module tb_gpi_cond;

  logic       wb_clk;
  logic       wb_rst_n;
  logic [7:0] pin_i;
  logic [7:0] gpi;
  logic [7:0] fall;
  logic [7:0] rise;
  logic       tick;

  int checks;
  int failures;

  gpi_cond #(
    .CLK_DIV(4),
    .DB_CNT (3)
  ) dut (
    .wb_clk  (wb_clk),
    .wb_rst_n(wb_rst_n),
    .pin_i   (pin_i),
    .gpi     (gpi),
    .fall    (fall),
    .rise    (rise),
    .tick    (tick)
  );

  // Free-running 10-unit clock.
  initial begin
    wb_clk = 1'b0;
    forever #5 wb_clk = ~wb_clk;
  end

  task automatic check8(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] exp_gpi,
                               input logic [7:0] exp_fall,
                               input logic [7:0] exp_rise);
    check8({tag, ".gpi"},  gpi,  exp_gpi);
    check8({tag, ".fall"}, fall, exp_fall);
    check8({tag, ".rise"}, rise, exp_rise);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  // Advance to the next falling edge where tick is high, bounded.
  task automatic wait_tick(input string tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk);
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    assert (found === 1'b1) else begin
      failures++;
      $error("[TB] FAIL %s tick_timeout observed=0 expected=1", tag);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with all pins asserted: outputs must stay inactive.
    wb_rst_n = 1'b0;
    pin_i    = 8'h00;
    cyc(3);
    check_outputs("reset", 8'hFF, 8'h00, 8'h00);
    check8("reset.tick", {7'b0, tick}, 8'h00);
    pin_i    = 8'hFF;
    wb_rst_n = 1'b1;
    cyc(3);
    check8("tick_phase.n3", {7'b0, tick}, 8'h00);
    cyc(1);
    check8("tick_phase.n4", {7'b0, tick}, 8'h01);
    check8("tick_phase.gpi", gpi, 8'hFF);
    cyc(1);
    check8("tick_phase.n5", {7'b0, tick}, 8'h00);

    // Short glitch on pin 5 between ticks has no effect.
    wait_tick("glitch");
    pin_i = 8'hDF;
    cyc(2);
    pin_i = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      check_outputs("glitch", 8'hFF, 8'h00, 8'h00);
      cyc(1);
    end

    // Clean press on pin 0: commit 13 edges after a tick-aligned change.
    wait_tick("press");
    pin_i = 8'hFE;
    cyc(12);
    check_outputs("press.before", 8'hFF, 8'h00, 8'h00);
    cyc(1);
    check_outputs("press.commit", 8'hFE, 8'h01, 8'h00);
    cyc(1);
    check_outputs("press.after", 8'hFE, 8'h00, 8'h00);

    // Release pin 0 again.
    wait_tick("release");
    pin_i = 8'hFF;
    cyc(12);
    check_outputs("release.before", 8'hFE, 8'h00, 8'h00);
    cyc(1);
    check_outputs("release.commit", 8'hFF, 8'h00, 8'h01);
    cyc(1);
    check_outputs("release.after", 8'hFF, 8'h00, 8'h00);

    // Bounce on pin 3 after two ticks restarts the count.
    wait_tick("bounce");
    pin_i = 8'hF7;
    cyc(10);
    pin_i = 8'hFF;
    cyc(1);
    pin_i = 8'hF7;
    cyc(2);
    check_outputs("bounce.third_tick", 8'hFF, 8'h00, 8'h00);
    cyc(11);
    check_outputs("bounce.before", 8'hFF, 8'h00, 8'h00);
    cyc(1);
    check_outputs("bounce.commit", 8'hF7, 8'h08, 8'h00);

    // Settle low nibble asserted (pin 3 is already committed low).
    wait_tick("settle");
    pin_i = 8'hF0;
    cyc(13);
    check_outputs("settle.commit", 8'hF0, 8'h07, 8'h00);

    // All eight channels flip on the same tick.
    wait_tick("simul");
    pin_i = 8'h0F;
    cyc(12);
    check_outputs("simul.before", 8'hF0, 8'h00, 8'h00);
    cyc(1);
    check_outputs("simul.commit", 8'h0F, 8'hF0, 8'h0F);
    cyc(1);
    check_outputs("simul.after", 8'h0F, 8'h00, 8'h00);

    // Asynchronous reset clears outputs without a clock edge.
    pin_i    = 8'hFF;
    wb_rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 8'hFF, 8'h00, 8'h00);
    cyc(1);
    wb_rst_n = 1'b1;

    // Reset after two ticks of pin 7 low discards the progress.
    wait_tick("midreset");
    pin_i = 8'h7F;
    cyc(10);
    check_outputs("midreset.pre", 8'hFF, 8'h00, 8'h00);
    wb_rst_n = 1'b0;
    cyc(1);
    wb_rst_n = 1'b1;
    cyc(4);
    check8("midreset.tick", {7'b0, tick}, 8'h01);
    cyc(1);
    check_outputs("midreset.first_tick", 8'hFF, 8'h00, 8'h00);
    cyc(7);
    check_outputs("midreset.before", 8'hFF, 8'h00, 8'h00);
    cyc(1);
    check_outputs("midreset.commit", 8'h7F, 8'h80, 8'h00);
    cyc(1);
    check_outputs("midreset.after", 8'h7F, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
